// File: rtl/mdu_iter_if.sv
// mdu_iter_if: request/response bundle between the execute stage and mdu_iter
interface mdu_iter_if #(parameter int XLEN = 32);
    logic start, kill, busy, done;
    logic [2:0] funct3;
    logic [XLEN-1:0] op_a, op_b, result;
    modport master (output start, kill, funct3, op_a, op_b, input busy, done, result);
    modport slave (input start, kill, funct3, op_a, op_b, output busy, done, result);
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit with fixed XLEN+2 cycle latency
module mdu_iter #(parameter int XLEN = 32) (
    input logic clk,
    input logic rst,
    mdu_iter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
    localparam int CW = $clog2(XLEN);
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] f3_q, f3_d;
    logic sa_q, sa_d, sb_q, sb_d, busy_q, busy_d, done_q, done_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, quo_q, quo_d, result_q, result_d;
    logic [2*XLEN:0] acc_q, acc_d;
    logic sgn_a, sgn_b, ge;
    logic [XLEN:0] trial, sum;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] quo_s, rem_s, mul_r, div_r;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.result = result_q;
    always_comb begin
        sgn_a = bus.funct3[2] ? ~bus.funct3[0] : bus.funct3[1] ^ bus.funct3[0];
        sgn_b = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1] & bus.funct3[0];
        trial = {acc_q[XLEN-1:0], a_q[cnt_q]};
        ge = trial >= {1'b0, b_q};
        sum = acc_q[2*XLEN:XLEN] + (b_q[0] ? {1'b0, a_q} : '0);
        prod = (sa_q ^ sb_q) ? -acc_q[2*XLEN-1:0] : acc_q[2*XLEN-1:0];
        // divide-by-zero quotient is forced; overflow falls out of the magnitude math
        quo_s = ~|b_q ? '1 : (sa_q ^ sb_q) ? -quo_q : quo_q;
        rem_s = sa_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        mul_r = f3_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        div_r = f3_q[1] ? rem_s : quo_s;
        state_d = state_q;
        cnt_d = cnt_q;
        f3_d = f3_q;
        sa_d = sa_q;
        sb_d = sb_q;
        a_d = a_q;
        b_d = b_q;
        quo_d = quo_q;
        acc_d = acc_q;
        busy_d = busy_q;
        done_d = 1'b0;
        result_d = result_q;
        if (state_q == IDLE && bus.start) begin
            state_d = CALC;
            busy_d = 1'b1;
            cnt_d = CW'(XLEN - 1);
            f3_d = bus.funct3;
            sa_d = sgn_a & bus.op_a[XLEN-1];
            sb_d = sgn_b & bus.op_b[XLEN-1];
            a_d = sa_d ? -bus.op_a : bus.op_a;
            b_d = sb_d ? -bus.op_b : bus.op_b;
            quo_d = '0;
            acc_d = '0;
        end else if (state_q == CALC) begin
            state_d = cnt_q == '0 ? FIN : CALC;
            cnt_d = cnt_q - 1'b1;
            if (f3_q[2]) begin
                acc_d = (2*XLEN+1)'(ge ? trial - {1'b0, b_q} : trial);
                quo_d[cnt_q] = ge;
            end else begin
                acc_d = {1'b0, sum, acc_q[XLEN-1:1]};
                b_d = b_q >> 1;
            end
        end else if (state_q == FIN) begin
            state_d = IDLE;
            busy_d = 1'b0;
            done_d = 1'b1;
            result_d = f3_q[2] ? div_r : mul_r;
        end
        if (bus.kill) begin
            state_d = IDLE;
            busy_d = 1'b0;
            done_d = 1'b0;
            result_d = result_q;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            f3_q <= '0;
            sa_q <= 1'b0;
            sb_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
            quo_q <= '0;
            acc_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            f3_q <= f3_d;
            sa_q <= sa_d;
            sb_q <= sb_d;
            a_q <= a_d;
            b_q <= b_d;
            quo_q <= quo_d;
            acc_q <= acc_d;
            busy_q <= busy_d;
            done_q <= done_d;
            result_q <= result_d;
        end
    end
endmodule
